pe_stream_feeder: RTL
=====================

PE_STREAM_FEEDER -- requirements
Module: pe_stream_feeder

Interface
REQ-001 Parameter FIFO_DEPTH, default 2: sample FIFO entries; power of two, at least 2.
REQ-002 Parameter FLUSH_PAIRS, default 4: number of zero LSB/MSB pairs emitted on flush.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 w_valid / w_ready  input / output  1 / 1  weight handshake; transfer occurs when both are 1 on a clk edge.
REQ-006 w_data  input  4  weight code: bit3 is the sign, bits2:0 the shift amount.
REQ-007 s_valid / s_ready  input / output  1 / 1  sample handshake.
REQ-008 s_x  input  8  x operand.
REQ-009 s_y  input  16  partial-sum operand.
REQ-010 flush  input  1  one-cycle pulse requesting a pipeline drain.
REQ-011 pe_xorw  output  8  drives the PE xOrW port.
REQ-012 pe_yin  output  8  drives the PE yIn port.
REQ-013 pe_ctrl  output  3  drives the PE ctrl port: bit0 StoreW, bit1 LSB, bit2 Circulate.
REQ-014 pe_real  output  1  1 when the current pair carries a FIFO sample; 0 for bubble or flush pairs.
REQ-015 busy  output  1  1 in any state other than IDLE.

Function
REQ-016 All pe_* outputs and busy SHALL be registered.
REQ-017 The FSM SHALL have the states IDLE, LOADW, LSB, MSB and FLUSH.
REQ-018 IDLE outputs: pe_ctrl=100, pe_xorw=0, pe_yin=0, pe_real=0.
  - w_ready=1 only in IDLE.
  - A weight transfer captures w_data; the next state is LOADW.
REQ-019 LOADW lasts exactly 1 cycle.
  - Outputs: pe_ctrl=001, pe_xorw={0000,w}, pe_yin=0.
  - Next state: LSB.
REQ-020 LSB outputs: pe_ctrl=010, pe_xorw=x, pe_yin=y[7:0].
  - Next state: MSB, always.
REQ-021 MSB outputs: pe_ctrl=100, pe_xorw=x (same x as the preceding LSB cycle), pe_yin=y[15:8].
REQ-022 On entry to LSB from LOADW or MSB:
  - FIFO not empty: pop the head into the x/y holding register; pe_real=1 for both cycles of the pair.
  - FIFO empty: emit a bubble pair with x=0, y=0, pe_real=0.
REQ-023 MSB transition priority:
  - FIFO not empty: go to LSB.
  - Else, flush pending: go to FLUSH.
  - Else: go to LSB (bubble).
REQ-024 FLUSH SHALL emit FLUSH_PAIRS zero pairs, alternating the ctrl=010 and ctrl=100 patterns, using a pair counter, then go to IDLE.
REQ-025 In FLUSH, samples stay in the FIFO and are not popped; they wait for the next weight load.
REQ-026 s_ready = FIFO not full, in every state.
  - Samples are accepted in IDLE; they wait until after LOADW.
REQ-027 Push and pop in the same cycle are both honoured; a push to a full FIFO is impossible because s_ready=0.
REQ-028 A flush pulse in LSB, MSB or LOADW sets flush_pending.
  - flush_pending clears on entry to FLUSH.
  - A flush pulse in IDLE or FLUSH is ignored.
REQ-029 flush with s_valid in the same cycle: the sample is accepted and emitted before the flush pairs.
REQ-030 Once started, the pair alignment (LSB then MSB) SHALL never break, so that one pair is emitted every 2 cycles.

Reset
REQ-031 While rst_n=0:
  - state=IDLE, FIFO empty, flush_pending=0, pair counter=0, weight=0, holding register=0.
  - Outputs at IDLE values; w_ready=1; s_ready=1; busy=0.
REQ-032 Reset asserted mid-pair SHALL abandon the pair immediately; no partial pair resumes after release.

Structure
REQ-033 A shared package SHALL hold:
  - the FSM state enum;
  - PE control constants CTRL_STOREW=001, CTRL_LSB=010, CTRL_CIRC=100, CTRL_IDLE=100.
REQ-034 The FIFO SHALL be a separate sub-module, sample_fifo: 24-bit entries ({x,y}), FIFO_DEPTH entries, full and empty flags, and the same clk/rst_n.

Verification
REQ-035 Weight 1011, then sample x=10110101, y=0101110111001101 -> outputs:
  - ctrl=001, xorw=00001011;
  - ctrl=010, xorw=10110101, yin=11001101, real=1;
  - ctrl=100, xorw=10110101, yin=01011101, real=1.
REQ-036 Weight loaded, then samples 10110101/5DCD, 11110000/AAAA, 11001100/CCCC pushed back-to-back -> three contiguous real pairs, yin sequence CD,5D,AA,AA,CC,CC.
REQ-037 Weight loaded with the FIFO empty for 3 pairs -> 3 bubble pairs (xorw=0, yin=0, real=0), alternating ctrl 010/100.
REQ-038 Flush pulsed with 2 samples queued -> 2 real pairs, then 4 zero pairs, then IDLE with busy=0 and w_ready=1.
REQ-039 FIFO filled to 2 entries in IDLE -> s_ready=0; push and pop together in LSB keeps the count unchanged.
REQ-040 rst_n dropped during an MSB cycle -> outputs at IDLE values immediately; after release, FIFO empty and a new weight load is required.

Source files
------------

// File: rtl/pe_stream_feeder_pkg.sv
// Shared definitions for the PE stream feeder: FSM states and PE control codes.
package pe_stream_feeder_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOADW = 3'd1,
    LSB   = 3'd2,
    MSB   = 3'd3,
    FLUSH = 3'd4
  } state_e;

  // PE ctrl bits: bit0 StoreW, bit1 LSB, bit2 Circulate
  localparam logic [2:0] CTRL_STOREW = 3'b001;
  localparam logic [2:0] CTRL_LSB    = 3'b010;
  localparam logic [2:0] CTRL_CIRC   = 3'b100;
  localparam logic [2:0] CTRL_IDLE   = 3'b100;

  // One queued sample is {x[7:0], y[15:0]}
  localparam int SAMPLE_W = 24;

endpackage

// File: rtl/pe_stream_feeder_sample_fifo.sv
// Small synchronous FIFO holding {x,y} samples until the feeder pairs them out.
module sample_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  // Advance pointers independently so a simultaneous push and pop both take effect
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  // Pointer registers; reset empties the FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Sample storage, written at the write pointer on an accepted push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/pe_stream_feeder.sv
// Feeds a bit-serial PE: loads a weight, then streams samples as LSB/MSB pairs,
// inserting bubble pairs when starved and draining with zero pairs on flush.
module pe_stream_feeder
  import pe_stream_feeder_pkg::*;
#(
  parameter int FIFO_DEPTH  = 2,
  parameter int FLUSH_PAIRS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        w_valid,
  output logic        w_ready,
  input  logic [3:0]  w_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_x,
  input  logic [15:0] s_y,
  input  logic        flush,
  output logic [7:0]  pe_xorw,
  output logic [7:0]  pe_yin,
  output logic [2:0]  pe_ctrl,
  output logic        pe_real,
  output logic        busy
);

  localparam int FLUSH_CYCLES = 2 * FLUSH_PAIRS;
  localparam int CNT_W        = $clog2(FLUSH_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLUSH_CYCLES - 1);

  state_e                state_q, state_d;
  logic [3:0]            weight_q, weight_d;
  logic [SAMPLE_W-1:0]   hold_q, hold_d;
  logic                  flush_pending_q, flush_pending_d;
  logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;
  logic [2:0]            pe_ctrl_q, pe_ctrl_d;
  logic [7:0]            pe_xorw_q, pe_xorw_d;
  logic [7:0]            pe_yin_q, pe_yin_d;
  logic                  pe_real_q, pe_real_d;
  logic                  busy_q, busy_d;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [SAMPLE_W-1:0]   fifo_rdata;
  logic                  load_pair;
  logic                  pair_real;

  assign w_ready   = (state_q == IDLE);
  assign s_ready   = !fifo_full;
  assign fifo_push = s_valid && s_ready;

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata ({s_x, s_y}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state logic: sequencing, flush tracking and pair loading from the FIFO
  always_comb begin
    state_d         = state_q;
    weight_d        = weight_q;
    hold_d          = hold_q;
    flush_pending_d = flush_pending_q;
    flush_cnt_d     = flush_cnt_q;
    fifo_pop        = 1'b0;
    load_pair       = 1'b0;
    pair_real       = pe_real_q;

    case (state_q)
      IDLE: begin
        if (w_valid) begin
          weight_d = w_data;
          state_d  = LOADW;
        end
      end
      LOADW: begin
        if (flush) flush_pending_d = 1'b1;
        state_d   = LSB;
        load_pair = 1'b1;
      end
      LSB: begin
        if (flush) flush_pending_d = 1'b1;
        state_d = MSB;
      end
      MSB: begin
        if (flush) flush_pending_d = 1'b1;
        if (!fifo_empty) begin
          state_d   = LSB;
          load_pair = 1'b1;
        end else if (flush_pending_q) begin
          state_d         = FLUSH;
          flush_pending_d = 1'b0;
          flush_cnt_d     = '0;
        end else begin
          state_d   = LSB;
          load_pair = 1'b1;
        end
      end
      FLUSH: begin
        if (flush_cnt_q == CNT_LAST) begin
          state_d     = IDLE;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_pair) begin
      if (!fifo_empty) begin
        fifo_pop  = 1'b1;
        hold_d    = fifo_rdata;
        pair_real = 1'b1;
      end else begin
        hold_d    = '0;
        pair_real = 1'b0;
      end
    end
  end

  // Output decode from the state being entered so the registered outputs line up with state_q
  always_comb begin
    pe_ctrl_d = CTRL_IDLE;
    pe_xorw_d = '0;
    pe_yin_d  = '0;
    pe_real_d = 1'b0;
    case (state_d)
      LOADW: begin
        pe_ctrl_d = CTRL_STOREW;
        pe_xorw_d = {4'b0000, weight_d};
      end
      LSB: begin
        pe_ctrl_d = CTRL_LSB;
        pe_xorw_d = hold_d[23:16];
        pe_yin_d  = hold_d[7:0];
        pe_real_d = pair_real;
      end
      MSB: begin
        pe_ctrl_d = CTRL_CIRC;
        pe_xorw_d = hold_d[23:16];
        pe_yin_d  = hold_d[15:8];
        pe_real_d = pair_real;
      end
      FLUSH: begin
        pe_ctrl_d = flush_cnt_d[0] ? CTRL_CIRC : CTRL_LSB;
      end
      default: pe_ctrl_d = CTRL_IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, datapath and output registers; reset abandons any pair in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      weight_q        <= '0;
      hold_q          <= '0;
      flush_pending_q <= 1'b0;
      flush_cnt_q     <= '0;
      pe_ctrl_q       <= CTRL_IDLE;
      pe_xorw_q       <= '0;
      pe_yin_q        <= '0;
      pe_real_q       <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      weight_q        <= weight_d;
      hold_q          <= hold_d;
      flush_pending_q <= flush_pending_d;
      flush_cnt_q     <= flush_cnt_d;
      pe_ctrl_q       <= pe_ctrl_d;
      pe_xorw_q       <= pe_xorw_d;
      pe_yin_q        <= pe_yin_d;
      pe_real_q       <= pe_real_d;
      busy_q          <= busy_d;
    end
  end

  assign pe_ctrl = pe_ctrl_q;
  assign pe_xorw = pe_xorw_q;
  assign pe_yin  = pe_yin_q;
  assign pe_real = pe_real_q;
  assign busy    = busy_q;

endmodule
